mem_ctrl: RTL and testbench

Memory-port arbiter and sequencer between the fetch stage (pc_reg/if path feeding if_id) and the mem stage, sharing one byte-wide synchronous RAM port. It grants one requester at a time and serialises 32-bit instruction fetches and 8/16/32-bit data accesses into byte transfers. It reassembles little-endian read data and raises per-requester stall requests to ctrl. Fetches are cancelled by a branch/jump from id.

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory-port controller.
// Imported by the bus interface and the controller itself.
package mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  // Encoding 2'b11 is deliberately treated as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of fetch, data-access, RAM and stall signals around mem_ctrl.
// slave = controller side, master = pipeline/RAM side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                  jumpout;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_inst;
  logic                  if_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_dout;
  logic                  ram_wr;
  logic [7:0]            ram_din;
  logic                  stall_req_if;
  logic                  stall_req_mem;

  modport slave (
    input  jumpout, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr,
           mem_wdata, ram_din,
    output if_inst, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr,
           stall_req_if, stall_req_mem
  );

  modport master (
    output jumpout, if_req, if_addr, mem_req, mem_we, mem_len, mem_addr,
           mem_wdata, ram_din,
    input  if_inst, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr,
           stall_req_if, stall_req_mem
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and data requests onto one byte-wide synchronous RAM port,
// serialising word/half/byte accesses and reassembling little-endian reads.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  mem_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            len_q, len_d;
  owner_e                owner_q, owner_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  mem_done_q, mem_done_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [7:0]            ram_dout_c;
  logic                  ram_wr_c;
  logic [5:0]            rd_shift;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    owner_d     = owner_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    if_inst_d   = '0;
    mem_done_d  = 1'b0;
    mem_rdata_d = '0;
    ram_addr_c  = '0;
    ram_dout_c  = '0;
    ram_wr_c    = 1'b0;
    // Bytes arrive into the top of asm; shift down so short reads zero-extend.
    rd_shift    = {3'd4 - len_q, 3'b000};

    unique case (state_q)
      MEM_IDLE: begin
        cnt_d = '0;
        asm_d = '0;
        if (bus.mem_req) begin
          base_d  = bus.mem_addr;
          len_d   = len_bytes(bus.mem_len);
          owner_d = OWNER_MEM;
          wdata_d = bus.mem_wdata;
          state_d = bus.mem_we ? MEM_WR : MEM_RD;
        end else if (bus.if_req && !bus.jumpout) begin
          base_d  = bus.if_addr;
          len_d   = 3'd4;
          owner_d = OWNER_IF;
          state_d = MEM_RD;
        end
      end

      MEM_RD: begin
        if (cnt_q < len_q) begin
          ram_addr_c = base_q + ADDR_WIDTH'(cnt_q);
        end
        // RAM data lags its address by one cycle, so cnt=k carries byte k-1.
        if (cnt_q != 3'd0) begin
          asm_d = {bus.ram_din, asm_q[DATA_WIDTH-1:8]};
        end
        cnt_d = cnt_q + 3'd1;
        if (owner_q == OWNER_IF && bus.jumpout) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d = MEM_DONE;
          cnt_d   = '0;
          if (owner_q == OWNER_IF) begin
            if_done_d = 1'b1;
            if_inst_d = asm_d >> rd_shift;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = asm_d >> rd_shift;
          end
        end
      end

      MEM_WR: begin
        ram_addr_c = base_q + ADDR_WIDTH'(cnt_q);
        ram_wr_c   = 1'b1;
        ram_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d    = MEM_DONE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      MEM_DONE: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      owner_q     <= OWNER_IF;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      len_q       <= len_d;
      owner_q     <= owner_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.ram_addr      = ram_addr_c;
  assign bus.ram_dout      = ram_dout_c;
  assign bus.ram_wr        = ram_wr_c;
  assign bus.if_inst       = if_inst_q;
  assign bus.if_done       = if_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.stall_req_if  = bus.if_req & ~if_done_q;
  assign bus.stall_req_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array memory model and a latency table.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // RAM environment (byte-wide, registered read) and the reference image.
  logic [7:0]  ram_mem [0:4095] = '{default: 8'h00};
  logic [7:0]  exp_mem [0:4095] = '{default: 8'h00};
  logic        poke_en   = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) ram_mem[poke_addr] <= poke_data;
    else if (bus.ram_wr) ram_mem[bus.ram_addr[11:0]] <= bus.ram_dout;
    bus.ram_din <= ram_mem[bus.ram_addr[11:0]];
  end

  // Per-cycle trace of one driven scenario, index = cycles after request.
  logic [31:0] tr_addr     [0:31];
  logic        tr_wr       [0:31];
  logic [7:0]  tr_dout     [0:31];
  logic        tr_stall_if [0:31];
  logic        tr_stall_mem[0:31];
  int          if_done_at, mem_done_at;
  logic [31:0] if_data, mem_data;

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] ak = a + 32'(k);
      r = r | (32'(exp_mem[ak[11:0]]) << (8 * k));
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ak = a + 32'(k);
      logic [31:0] sh = wd >> (8 * k);
      exp_mem[ak[11:0]] = sh[7:0];
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a[11:0]; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    exp_mem[a[11:0]] = d;
  endtask

  // Drives requests cycle by cycle and records what the DUT does; returns at
  // the start of a cycle with all requests dropped.
  task automatic drive(input bit if_on, input logic [31:0] ia,
                       input bit m_on, input bit we, input logic [1:0] len,
                       input logic [31:0] ma, input logic [31:0] wd,
                       input int jump_at, input int rst_at);
    int c = 0;
    bit if_pend = if_on;
    bit m_pend  = m_on;
    if_done_at = -1; mem_done_at = -1; if_data = '0; mem_data = '0;
    for (int i = 0; i < 32; i++) begin
      tr_addr[i] = '0; tr_wr[i] = 1'b0; tr_dout[i] = '0;
      tr_stall_if[i] = 1'b0; tr_stall_mem[i] = 1'b0;
    end
    while (c < 32) begin
      bus.if_req = if_pend; bus.if_addr = ia;
      bus.mem_req = m_pend; bus.mem_we = we; bus.mem_len = len;
      bus.mem_addr = ma; bus.mem_wdata = wd;
      bus.jumpout = (c == jump_at);
      rst = (c == rst_at);
      @(negedge clk);
      tr_addr[c] = bus.ram_addr; tr_wr[c] = bus.ram_wr; tr_dout[c] = bus.ram_dout;
      tr_stall_if[c] = bus.stall_req_if; tr_stall_mem[c] = bus.stall_req_mem;
      if (bus.if_done) begin
        if (if_done_at < 0) begin if_done_at = c; if_data = bus.if_inst; end
        if_pend = 1'b0;
      end
      if (bus.mem_done) begin
        if (mem_done_at < 0) begin mem_done_at = c; mem_data = bus.mem_rdata; end
        m_pend = 1'b0;
      end
      @(posedge clk); #1;
      c++;
      if (!if_pend && !m_pend) break;
      if (jump_at >= 0 && if_on && c > jump_at) break;
      if (rst_at >= 0 && c > rst_at) break;
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.jumpout = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.if_req = 1'b1; bus.mem_req = 1'b1;
    bus.if_addr = 32'h0000_0100; bus.mem_addr = 32'h0000_0200;
    bus.mem_we = 1'b1; bus.mem_wdata = 32'h1234_5678; bus.mem_len = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 9;
    if (bus.if_inst   !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst got %h want 0", bus.if_inst); end
    if (bus.if_done   !== 1'b0)  begin n_fail++; $display("FAIL reset_if_done got %b want 0", bus.if_done); end
    if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_rdata got %h want 0", bus.mem_rdata); end
    if (bus.mem_done  !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_done got %b want 0", bus.mem_done); end
    if (bus.ram_addr  !== 32'h0) begin n_fail++; $display("FAIL reset_ram_addr got %h want 0", bus.ram_addr); end
    if (bus.ram_dout  !== 8'h0)  begin n_fail++; $display("FAIL reset_ram_dout got %h want 0", bus.ram_dout); end
    if (bus.ram_wr    !== 1'b0)  begin n_fail++; $display("FAIL reset_ram_wr got %b want 0", bus.ram_wr); end
    if (bus.stall_req_if  !== 1'b1) begin n_fail++; $display("FAIL reset_stall_if got %b want 1", bus.stall_req_if); end
    if (bus.stall_req_mem !== 1'b1) begin n_fail++; $display("FAIL reset_stall_mem got %b want 1", bus.stall_req_mem); end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    #1;
    n_checks += 2;
    if (bus.stall_req_if  !== 1'b0) begin n_fail++; $display("FAIL reset_stall_if_low got %b want 0", bus.stall_req_if); end
    if (bus.stall_req_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stall_mem_low got %b want 0", bus.stall_req_mem); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_fetch();
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, -1, -1);
    n_checks += 4;
    if (if_done_at !== 6) begin n_fail++; $display("FAIL fetch_latency got %0d want 6", if_done_at); end
    if (if_data !== 32'h0010_0513) begin n_fail++; $display("FAIL fetch_data got %h want 00100513", if_data); end
    if (mem_done_at !== -1) begin n_fail++; $display("FAIL fetch_spurious_mem_done at %0d want none", mem_done_at); end
    if (tr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL fetch_idle_addr got %h want 0", tr_addr[0]); end
    for (int k = 0; k < 4; k++) begin
      n_checks += 2;
      if (tr_addr[1+k] !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL fetch_addr%0d got %h want %h", k, tr_addr[1+k], 32'h100 + 32'(k)); end
      if (tr_wr[1+k] !== 1'b0) begin n_fail++; $display("FAIL fetch_wr%0d got %b want 0", k, tr_wr[1+k]); end
    end
    for (int c = 0; c <= 6; c++) begin
      n_checks++;
      if (tr_stall_if[c] !== (c < 6)) begin n_fail++; $display("FAIL fetch_stall_c%0d got %b want %b", c, tr_stall_if[c], c < 6); end
    end
    $display("txn fetch 0x100 -> %h at R+%0d", if_data, if_done_at);
  endtask

  task automatic test_store_load();
    logic [31:0] wd = 32'hDEAD_BEEF;
    logic [7:0]  want_b;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h200, wd, -1, -1);
    n_checks += 4;
    if (mem_done_at !== 5) begin n_fail++; $display("FAIL store_latency got %0d want 5", mem_done_at); end
    if (if_done_at !== -1) begin n_fail++; $display("FAIL store_spurious_if_done at %0d", if_done_at); end
    if (tr_wr[0] !== 1'b0) begin n_fail++; $display("FAIL store_wr_idle got %b want 0", tr_wr[0]); end
    if (tr_wr[5] !== 1'b0) begin n_fail++; $display("FAIL store_wr_done got %b want 0", tr_wr[5]); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] sh = wd >> (8 * k);
      want_b = sh[7:0];
      n_checks += 3;
      if (tr_wr[1+k] !== 1'b1) begin n_fail++; $display("FAIL store_wr%0d got %b want 1", k, tr_wr[1+k]); end
      if (tr_addr[1+k] !== 32'h200 + 32'(k)) begin n_fail++; $display("FAIL store_addr%0d got %h want %h", k, tr_addr[1+k], 32'h200 + 32'(k)); end
      if (tr_dout[1+k] !== want_b) begin n_fail++; $display("FAIL store_byte%0d got %h want %h", k, tr_dout[1+k], want_b); end
    end
    model_write(32'h200, 4, wd);
    $display("txn store word %h at 0x200 done R+%0d", wd, mem_done_at);

    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h201, 32'h0, -1, -1);
    n_checks += 3;
    if (mem_done_at !== 3) begin n_fail++; $display("FAIL loadb_latency got %0d want 3", mem_done_at); end
    if (mem_data !== 32'h0000_00BE) begin n_fail++; $display("FAIL loadb_data got %h want 000000be", mem_data); end
    if (tr_addr[1] !== 32'h201) begin n_fail++; $display("FAIL loadb_addr got %h want 201", tr_addr[1]); end
    $display("txn load byte 0x201 -> %h at R+%0d", mem_data, mem_done_at);
  endtask

  task automatic test_priority();
    poke(32'h300, 8'($urandom())); poke(32'h301, 8'($urandom()));
    drive(1'b1, 32'h100, 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, -1, -1);
    n_checks += 8;
    if (mem_done_at !== 4) begin n_fail++; $display("FAIL prio_mem_latency got %0d want 4", mem_done_at); end
    if (mem_data !== model_read(32'h300, 2)) begin n_fail++; $display("FAIL prio_mem_data got %h want %h", mem_data, model_read(32'h300, 2)); end
    if (if_done_at !== 11) begin n_fail++; $display("FAIL prio_if_latency got %0d want 11", if_done_at); end
    if (if_data !== model_read(32'h100, 4)) begin n_fail++; $display("FAIL prio_if_data got %h want %h", if_data, model_read(32'h100, 4)); end
    if (tr_addr[1] !== 32'h300) begin n_fail++; $display("FAIL prio_mem_addr got %h want 300", tr_addr[1]); end
    if (tr_addr[6] !== 32'h100) begin n_fail++; $display("FAIL prio_if_addr got %h want 100", tr_addr[6]); end
    if (tr_stall_if[10] !== 1'b1) begin n_fail++; $display("FAIL prio_stall_if got %b want 1", tr_stall_if[10]); end
    if (tr_stall_mem[4] !== 1'b0) begin n_fail++; $display("FAIL prio_stall_mem got %b want 0", tr_stall_mem[4]); end
    $display("txn concurrent mem R+%0d if R+%0d", mem_done_at, if_done_at);
  endtask

  task automatic test_jump();
    for (int k = 0; k < 4; k++) poke(32'h400 + 32'(k), 8'($urandom()));
    drive(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2, -1);
    n_checks++;
    if (if_done_at !== -1) begin n_fail++; $display("FAIL jump_no_done got done at %0d", if_done_at); end
    drive(1'b1, 32'h400, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, -1, -1);
    n_checks += 3;
    if (tr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL jump_idle_after got %h want 0", tr_addr[0]); end
    if (if_done_at !== 6) begin n_fail++; $display("FAIL jump_refetch_latency got %0d want 6", if_done_at); end
    if (if_data !== model_read(32'h400, 4)) begin n_fail++; $display("FAIL jump_refetch_data got %h want %h", if_data, model_read(32'h400, 4)); end
    $display("txn jump then fetch 0x400 -> %h", if_data);
    // jumpout in IDLE blocks the grant; jumpout does not disturb a data load
    drive(1'b1, 32'h400, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 0, -1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h400, 32'h0, 1, -1);
    n_checks += 3;
    if (tr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL jump_idle_grant got %h want 0", tr_addr[0]); end
    if (mem_done_at !== 6) begin n_fail++; $display("FAIL jump_mem_latency got %0d want 6", mem_done_at); end
    if (mem_data !== model_read(32'h400, 4)) begin n_fail++; $display("FAIL jump_mem_data got %h want %h", mem_data, model_read(32'h400, 4)); end
    $display("txn jump in idle, load 0x400 -> %h", mem_data);
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] wd = $urandom();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h240, wd, -1, 2);
    n_checks++;
    if (mem_done_at !== -1) begin n_fail++; $display("FAIL rststore_no_done got done at %0d", mem_done_at); end
    model_write(32'h240, 2, wd);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks += 4;
      if (bus.ram_wr !== 1'b0) begin n_fail++; $display("FAIL rststore_wr c%0d got %b want 0", c, bus.ram_wr); end
      if (bus.ram_addr !== 32'h0) begin n_fail++; $display("FAIL rststore_addr c%0d got %h want 0", c, bus.ram_addr); end
      if (bus.ram_dout !== 8'h0) begin n_fail++; $display("FAIL rststore_dout c%0d got %h want 0", c, bus.ram_dout); end
      if (bus.mem_done !== 1'b0) begin n_fail++; $display("FAIL rststore_done c%0d got %b want 0", c, bus.mem_done); end
      @(posedge clk); #1;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h240, 32'h0, -1, -1);
    n_checks++;
    if (mem_data !== model_read(32'h240, 4)) begin n_fail++; $display("FAIL rststore_partial got %h want %h", mem_data, model_read(32'h240, 4)); end
    $display("txn reset mid-store, readback %h", mem_data);
  endtask

  task automatic test_wrap();
    logic [31:0] wd = $urandom();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, wd, -1, -1);
    n_checks += 5;
    if (mem_done_at !== 5) begin n_fail++; $display("FAIL wrap_latency got %0d want 5", mem_done_at); end
    if (tr_addr[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0 got %h want ffffffff", tr_addr[1]); end
    if (tr_addr[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", tr_addr[2]); end
    if (tr_addr[3] !== 32'h1) begin n_fail++; $display("FAIL wrap_addr2 got %h want 1", tr_addr[3]); end
    if (tr_addr[4] !== 32'h2) begin n_fail++; $display("FAIL wrap_addr3 got %h want 2", tr_addr[4]); end
    model_write(32'hFFFF_FFFF, 4, wd);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0, -1, -1);
    n_checks++;
    if (mem_data !== wd) begin n_fail++; $display("FAIL wrap_readback got %h want %h", mem_data, wd); end
    $display("txn wrap store/load %h", mem_data);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int unsigned mode = $urandom_range(0, 2);
      logic [31:0] r1 = $urandom();
      logic [31:0] r2 = $urandom();
      logic [31:0] ia = {r1[31:12], 6'b100000, r1[5:0]};
      logic [31:0] ma = {r2[31:12], 6'b100000, r2[5:0]};
      logic [31:0] wd = $urandom();
      logic [1:0]  len = 2'($urandom_range(0, 3));
      bit          we = 1'($urandom_range(0, 1));
      bit          if_on = (mode != 1);
      bit          m_on = (mode != 0);
      int          n = nbytes(len);
      int          m_lat = we ? n + 1 : n + 2;
      int          if_lat = m_on ? m_lat + 1 + 6 : 6;
      logic [31:0] m_exp = we ? 32'h0 : model_read(ma, n);
      logic [31:0] if_exp;
      drive(if_on, ia, m_on, we, len, ma, wd, -1, -1);
      if (m_on && we) model_write(ma, n, wd);
      if_exp = model_read(ia, 4);
      if (m_on) begin
        n_checks += 2;
        if (mem_done_at !== m_lat) begin n_fail++; $display("FAIL rnd%0d_mem_latency got %0d want %0d", t, mem_done_at, m_lat); end
        if (!we && mem_data !== m_exp) begin n_fail++; $display("FAIL rnd%0d_mem_data got %h want %h", t, mem_data, m_exp); end
        for (int k = 0; k < n; k++) begin
          logic [31:0] sh = wd >> (8 * k);
          n_checks += 2;
          if (tr_addr[1+k] !== ma + 32'(k)) begin n_fail++; $display("FAIL rnd%0d_mem_addr%0d got %h want %h", t, k, tr_addr[1+k], ma + 32'(k)); end
          if (tr_wr[1+k] !== we || (we && tr_dout[1+k] !== sh[7:0])) begin
            n_fail++; $display("FAIL rnd%0d_mem_wbyte%0d got wr=%b %h want wr=%b %h", t, k, tr_wr[1+k], tr_dout[1+k], we, sh[7:0]);
          end
        end
      end else begin
        n_checks++;
        if (mem_done_at !== -1) begin n_fail++; $display("FAIL rnd%0d_spurious_mem_done at %0d", t, mem_done_at); end
      end
      if (if_on) begin
        n_checks += 3;
        if (if_done_at !== if_lat) begin n_fail++; $display("FAIL rnd%0d_if_latency got %0d want %0d", t, if_done_at, if_lat); end
        if (if_data !== if_exp) begin n_fail++; $display("FAIL rnd%0d_if_data got %h want %h", t, if_data, if_exp); end
        if (tr_addr[if_lat-5] !== ia) begin n_fail++; $display("FAIL rnd%0d_if_addr got %h want %h", t, tr_addr[if_lat-5], ia); end
      end else begin
        n_checks++;
        if (if_done_at !== -1) begin n_fail++; $display("FAIL rnd%0d_spurious_if_done at %0d", t, if_done_at); end
      end
      $display("txn rnd%0d mode=%0d we=%b len=%0d ia=%h ma=%h if@%0d mem@%0d", t, mode, we, len, ia, ma, if_done_at, mem_done_at);
    end
  endtask

  initial begin
    bus.jumpout = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_jump();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
